// File: rtl/sevseg_scan_mux.sv
// Time-multiplexed seven-segment driver for NDIG common-anode digits with guard time and frame strobe.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module sevseg_scan_mux #(
  parameter int NDIG     = 4,
  parameter int TICK_DIV = 100000,
  parameter int GUARD    = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [4*NDIG-1:0] BCD,
  input  logic [NDIG-1:0]   DP,
  input  logic              EN,
  output logic [NDIG-1:0]   AN,
  output logic [6:0]        SEGN,
  output logic              DPN,
  output logic              FRAME
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

  logic [CW-1:0]   cnt;
  logic [IW-1:0]   idx;
  logic            cnt_wrap;
  logic [NDIG-1:0] sel;
  logic [NDIG-1:0] blank;
  logic [3:0]      code;
  logic            dp_bit;
  logic            off;
  logic [NDIG-1:0] an_nxt;
  logic [6:0]      segn_nxt;
  logic            dpn_nxt;

  function automatic logic [6:0] decode(input logic [3:0] c);
    logic [6:0] s;
    case (c)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign cnt_wrap = (cnt == CNT_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt_wrap) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic lz_run;

  // Walk down from the most significant digit; a digit stays blank only while every digit above it is blank too.
  always_comb begin
    lz_run = 1'b1;
    blank  = '0;
    for (int unsigned i = NDIG - 1; i > 0; i--) begin
      lz_run   = lz_run && (BCD[4*i +: 4] == 4'h0) && !DP[i];
      blank[i] = lz_run;
    end
  end
`else
  assign blank = '0;
`endif

  // Shift-based selects keep every index in range for any NDIG, including 1.
  always_comb begin
    sel      = NDIG'(1) << idx;
    code     = 4'(BCD >> {idx, 2'b00});
    dp_bit   = |(DP & sel);
    off      = !EN || (int'(cnt) < GUARD) || (|(blank & sel));
    an_nxt   = off ? '1 : ~sel;
    segn_nxt = off ? 7'h7F : decode(code);
    dpn_nxt  = off ? 1'b1 : ~dp_bit;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      AN    <= '1;
      SEGN  <= 7'h7F;
      DPN   <= 1'b1;
      FRAME <= 1'b0;
    end else begin
      AN    <= an_nxt;
      SEGN  <= segn_nxt;
      DPN   <= dpn_nxt;
      FRAME <= cnt_wrap && (idx == IDX_LAST);
    end
  end

endmodule
